paper_sequencer: RTL and testbench

- Control unit for the paper processor: owns the program counter and instruction register, and runs a fixed fetch/load/execute FSM.
- Fetches from a synchronous program ROM.
- Issues one-cycle register-file ops (INC/DEC/CLR) to the external register datapath.
- Resolves JMP, JNO (jump if no overflow) and ISZ (skip if zero).

---
 rtl/paper_sequencer.sv | 161 ++++++++++++++++
 tb/tb_paper_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paper_sequencer.sv
// Paper-processor control unit: PC/IR ownership and a fixed FETCH/LOAD/EXEC FSM.
// Optional single-step PAUSE state is enabled by defining SEQ_SINGLE_STEP_EN.
module paper_sequencer #(
  parameter int PC_W   = 4,
  parameter int RSEL_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic              imem_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [PC_W+2:0]   imem_rdata,
  output logic [RSEL_W-1:0] rf_sel,
  output logic              rf_inc,
  output logic              rf_dec,
  output logic              rf_clr,
  input  logic              rf_zero,
  input  logic              rf_ovf,
  output logic [PC_W-1:0]   pc,
  output logic              ovf_flag,
  output logic              halted,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_INC = 3'b001,
    OP_DEC = 3'b010,
    OP_JMP = 3'b011,
    OP_ISZ = 3'b100,
    OP_JNO = 3'b101,
    OP_CLR = 3'b110,
    OP_STP = 3'b111
  } op_t;

  state_t            r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic [PC_W+2:0]   r_ir, w_ir_nxt;
  logic              r_ovf, w_ovf_nxt;
  op_t               w_op;
  logic [PC_W-1:0]   w_opnd;
  logic [PC_W-1:0]   w_pc_p1;
  logic [PC_W-1:0]   w_pc_p2;
  logic              w_pause_req;

  assign w_op    = op_t'(r_ir[PC_W+2:PC_W]);
  assign w_opnd  = r_ir[PC_W-1:0];
  assign w_pc_p1 = r_pc + PC_W'(1);
  assign w_pc_p2 = r_pc + PC_W'(2);

`ifdef SEQ_SINGLE_STEP_EN
  assign w_pause_req = step_mode;
`else
  assign w_pause_req = 1'b0;
`endif

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ovf_flag  = r_ovf;
  assign rf_sel    = r_ir[RSEL_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Strobes are decoded from state so an async reset kills them immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_ovf_nxt   = r_ovf;
    imem_en     = 1'b0;
    rf_inc      = 1'b0;
    rf_dec      = 1'b0;
    rf_clr      = 1'b0;
    halted      = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pc_nxt    = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        busy        = 1'b1;
        imem_en     = 1'b1;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy        = 1'b1;
        w_ir_nxt    = imem_rdata;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        busy        = 1'b1;
        w_pc_nxt    = w_pc_p1;
        w_state_nxt = w_pause_req ? S_PAUSE : S_FETCH;
        case (w_op)
          OP_NOP: ;
          OP_INC: begin
            rf_inc    = 1'b1;
            w_ovf_nxt = rf_ovf;
          end
          OP_DEC: begin
            rf_dec    = 1'b1;
            w_ovf_nxt = rf_ovf;
          end
          OP_JMP: w_pc_nxt = w_opnd;
          OP_ISZ: w_pc_nxt = rf_zero ? w_pc_p2 : w_pc_p1;
          OP_JNO: w_pc_nxt = r_ovf ? w_pc_p1 : w_opnd;
          OP_CLR: rf_clr = 1'b1;
          OP_STP: begin
            w_pc_nxt    = r_pc;
            w_state_nxt = S_HALT;
          end
          default: ;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          w_pc_nxt    = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_FETCH;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step || !step_mode) w_state_nxt = S_FETCH;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_paper_sequencer.sv
// Directed self-checking bench for paper_sequencer with a behavioural synchronous ROM.
module tb_paper_sequencer;

  localparam int PC_W   = 4;
  localparam int RSEL_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic              step_mode = 1'b0;
  logic              step = 1'b0;
`endif
  logic              imem_en;
  logic [PC_W-1:0]   imem_addr;
  logic [PC_W+2:0]   imem_rdata = '0;
  logic [RSEL_W-1:0] rf_sel;
  logic              rf_inc, rf_dec, rf_clr;
  logic              rf_zero = 1'b0;
  logic              rf_ovf = 1'b0;
  logic [PC_W-1:0]   pc;
  logic              ovf_flag, halted, busy;

  logic [PC_W+2:0]   rom [16];
  int                n_checks = 0;
  int                n_errors = 0;
  int                n_inc = 0, n_dec = 0, n_clr = 0;
  int                b_inc, b_dec, b_clr;

  paper_sequencer #(.PC_W(PC_W), .RSEL_W(RSEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .rf_sel(rf_sel), .rf_inc(rf_inc), .rf_dec(rf_dec), .rf_clr(rf_clr),
    .rf_zero(rf_zero), .rf_ovf(rf_ovf), .pc(pc), .ovf_flag(ovf_flag),
    .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

  always @(posedge clk) begin
    if (rf_inc) n_inc++;
    if (rf_dec) n_dec++;
    if (rf_clr) n_clr++;
  end

  function automatic logic [PC_W+2:0] enc(input int op, input int opnd);
    logic [2:0] o;
    logic [PC_W-1:0] a;
    o = 3'(op);
    a = PC_W'(opnd);
    return {o, a};
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = enc(7, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check_eq("rst_imem_en", int'(imem_en), 0);
    check_eq("rst_pc", int'(pc), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_halted", int'(halted), 0);
    check_eq("rst_ovf", int'(ovf_flag), 0);
    check_eq("rst_strobes", int'({rf_inc, rf_dec, rf_clr}), 0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called while in FETCH; leaves the bench at the following instruction's FETCH.
  task automatic expect_fetch(input string tag, input int addr);
    check_eq({tag, "_en"}, int'(imem_en), 1);
    check_eq({tag, "_addr"}, int'(imem_addr), addr);
    tick(); tick(); tick();
  endtask

  task automatic snap();
    b_inc = n_inc; b_dec = n_dec; b_clr = n_clr;
  endtask

  initial begin
    // Test 1: immediate STP
    clear_rom();
    do_reset();
    snap();
    do_start();
    check_eq("t1_fetch_en", int'(imem_en), 1);
    check_eq("t1_fetch_busy", int'(busy), 1);
    tick();
    check_eq("t1_load_en", int'(imem_en), 0);
    tick();
    tick();
    check_eq("t1_halted", int'(halted), 1);
    check_eq("t1_busy", int'(busy), 0);
    check_eq("t1_pc", int'(pc), 0);
    check_eq("t1_strobes", (n_inc - b_inc) + (n_dec - b_dec) + (n_clr - b_clr), 0);

    // Test 2: INC r1 / JMP 0 loop
    clear_rom();
    rom[0] = enc(1, 1);
    rom[1] = enc(3, 0);
    rf_ovf = 1'b0;
    do_reset();
    snap();
    do_start();
    for (int c = 1; c <= 12; c++) begin
      check_eq($sformatf("t2_inc_c%0d", c), int'(rf_inc), (c % 6 == 3) ? 1 : 0);
      if (c % 6 == 3) check_eq($sformatf("t2_sel_c%0d", c), int'(rf_sel), 1);
      if (c % 3 == 1) check_eq($sformatf("t2_addr_c%0d", c), int'(imem_addr), ((c - 1) / 3) % 2);
      tick();
    end
    check_eq("t2_inc_count", n_inc - b_inc, 2);
    check_eq("t2_other_strobes", (n_dec - b_dec) + (n_clr - b_clr), 0);

    // Test 3: PC wrap on NOP at 15 and ISZ skip at 14
    clear_rom();
    rom[0]  = enc(3, 14);
    rom[14] = enc(4, 2);
    rom[15] = enc(0, 0);
    rf_zero = 1'b0;
    do_reset();
    do_start();
    expect_fetch("t3_a", 0);
    expect_fetch("t3_b", 14);
    expect_fetch("t3_c", 15);
    expect_fetch("t3_d", 0);
    rf_zero = 1'b1;
    expect_fetch("t3_e", 14);
    expect_fetch("t3_f", 0);
    rf_zero = 1'b0;

    // Test 4: overflow flag with JNO and CLR
    clear_rom();
    rom[0] = enc(1, 0);
    rom[1] = enc(6, 1);
    rom[2] = enc(5, 7);
    rom[3] = enc(2, 3);
    rom[4] = enc(5, 7);
    rom[7] = enc(7, 0);
    rf_ovf = 1'b1;
    do_reset();
    snap();
    do_start();
    expect_fetch("t4_inc", 0);
    check_eq("t4_ovf_after_inc", int'(ovf_flag), 1);
    expect_fetch("t4_clr", 1);
    check_eq("t4_ovf_after_clr", int'(ovf_flag), 1);
    expect_fetch("t4_jno1", 2);
    rf_ovf = 1'b0;
    expect_fetch("t4_dec", 3);
    check_eq("t4_ovf_after_dec", int'(ovf_flag), 0);
    expect_fetch("t4_jno2", 4);
    expect_fetch("t4_stp", 7);
    check_eq("t4_halted", int'(halted), 1);
    check_eq("t4_pc", int'(pc), 7);
    check_eq("t4_counts", (n_inc - b_inc) * 100 + (n_dec - b_dec) * 10 + (n_clr - b_clr), 111);

    // Test 5: reset during EXEC of DEC
    clear_rom();
    rom[0] = enc(2, 2);
    do_reset();
    do_start();
    tick();
    tick();
    check_eq("t5_dec_exec", int'(rf_dec), 1);
    check_eq("t5_sel", int'(rf_sel), 2);
    snap();
    rst_n = 1'b0;
    #1;
    check_eq("t5_dec_drop", int'(rf_dec), 0);
    check_eq("t5_pc", int'(pc), 0);
    check_eq("t5_busy", int'(busy), 0);
    check_eq("t5_halted", int'(halted), 0);
    tick();
    check_eq("t5_no_dec_commit", n_dec - b_dec, 0);
    rst_n = 1'b1;
    tick();
    check_eq("t5_idle_busy", int'(busy), 0);
    do_start();
    expect_fetch("t5_replay", 0);
    check_eq("t5_pc_after", int'(pc), 1);

`ifdef SEQ_SINGLE_STEP_EN
    // Test 6: single stepping
    clear_rom();
    rom[0] = enc(0, 0);
    rom[1] = enc(0, 0);
    rom[2] = enc(7, 0);
    do_reset();
    step_mode = 1'b1;
    do_start();
    check_eq("t6_f0", int'(imem_addr), 0);
    tick(); tick(); tick();
    check_eq("t6_p1_busy", int'(busy), 0);
    check_eq("t6_p1_halted", int'(halted), 0);
    check_eq("t6_p1_en", int'(imem_en), 0);
    tick(); tick();
    check_eq("t6_p1_hold_pc", int'(pc), 1);
    check_eq("t6_p1_hold_busy", int'(busy), 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    expect_fetch("t6_f1", 1);
    check_eq("t6_p2_busy", int'(busy), 0);
    tick();
    check_eq("t6_p2_hold_en", int'(imem_en), 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    expect_fetch("t6_f2", 2);
    check_eq("t6_halted", int'(halted), 1);
    check_eq("t6_pc", int'(pc), 2);
    step_mode = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
